// File: rtl/common_qptr_ctrl32_pkg.sv
// Shared widths and reset value for the 32-entry queue pointer controller.
package common_qptr_ctrl32_pkg;

  localparam int unsigned QPTR_IDX_W = 5;
  localparam int unsigned QPTR_W     = 6;
  localparam int unsigned QPTR_DEPTH = 32;

  typedef logic [QPTR_W-1:0]     qptr_t;
  typedef logic [QPTR_IDX_W-1:0] qidx_t;

  localparam qptr_t QPTR_RST = 6'd0;

endpackage

// File: rtl/common_qptr_ctrl32_if.sv
// Enqueue/dequeue handshake, flush and status bundle for common_qptr_ctrl32.
interface common_qptr_ctrl32_if;
  import common_qptr_ctrl32_pkg::*;

  logic  i_enq_valid;
  logic  o_enq_ready;
  qidx_t o_enq_ptr;
  logic  i_deq_ready;
  logic  o_deq_valid;
  qidx_t o_deq_ptr;
  logic  i_flush;
  qptr_t o_count;
  logic  o_full;
  logic  o_empty;
  logic  o_afull;

  modport master (
    output i_enq_valid, i_deq_ready, i_flush,
    input  o_enq_ready, o_enq_ptr, o_deq_valid, o_deq_ptr,
    input  o_count, o_full, o_empty, o_afull
  );

  modport slave (
    input  i_enq_valid, i_deq_ready, i_flush,
    output o_enq_ready, o_enq_ptr, o_deq_valid, o_deq_ptr,
    output o_count, o_full, o_empty, o_afull
  );

endinterface

// File: rtl/common_rtlrom_incr5.sv
// 5-bit increment table: q_o = a_i + 1 (mod 32), c_o set when a_i wraps from 31.
module common_rtlrom_incr5 (
  input  logic [4:0] a_i,
  output logic [4:0] q_o,
  output logic       c_o
);

  logic carry;

  // Ripple carry-in of 1; carry survives only while every lower bit is set.
  always_comb begin
    carry = 1'b1;
    q_o   = '0;
    for (int i = 0; i < 5; i++) begin
      q_o[i] = a_i[i] ^ carry;
      carry  = carry & a_i[i];
    end
    c_o = carry;
  end

endmodule

// File: rtl/common_qptr_ctrl32.sv
// Head/tail pointer, occupancy and flush control for a 32-entry circular queue.
module common_qptr_ctrl32
  import common_qptr_ctrl32_pkg::*;
#(
  parameter int unsigned AFULL_THRESH = 28
) (
  input logic                 clk,
  input logic                 resetn,
  common_qptr_ctrl32_if.slave q
);

  qptr_t head_r, head_d, tail_r, tail_d, count_r, count_d;
  qptr_t head_nxt, tail_nxt, count_inc, count_dec;
  qidx_t head_idx_inc, tail_idx_inc, count_lo_inc;
  logic  head_c, tail_c, count_c;
  logic  empty, full, enq_fire, deq_fire;

  common_rtlrom_incr5 u_tail_incr (
    .a_i (tail_r[QPTR_IDX_W-1:0]),
    .q_o (tail_idx_inc),
    .c_o (tail_c)
  );

  common_rtlrom_incr5 u_head_incr (
    .a_i (head_r[QPTR_IDX_W-1:0]),
    .q_o (head_idx_inc),
    .c_o (head_c)
  );

  common_rtlrom_incr5 u_count_incr (
    .a_i (count_r[QPTR_IDX_W-1:0]),
    .q_o (count_lo_inc),
    .c_o (count_c)
  );

  assign tail_nxt  = {tail_r[QPTR_W-1] ^ tail_c, tail_idx_inc};
  assign head_nxt  = {head_r[QPTR_W-1] ^ head_c, head_idx_inc};
  assign count_inc = {count_r[QPTR_W-1] ^ count_c, count_lo_inc};

  // Borrow-chain decrement, mirror image of the increment table.
  always_comb begin
    logic borrow;
    borrow    = 1'b1;
    count_dec = '0;
    for (int i = 0; i < int'(QPTR_W); i++) begin
      count_dec[i] = count_r[i] ^ borrow;
      borrow       = borrow & ~count_r[i];
    end
  end

  assign empty = (head_r == tail_r);
  assign full  = (head_r[QPTR_IDX_W-1:0] == tail_r[QPTR_IDX_W-1:0]) &&
                 (head_r[QPTR_W-1] != tail_r[QPTR_W-1]);

  assign enq_fire = q.i_enq_valid & ~full;
  assign deq_fire = q.i_deq_ready & ~empty;

  always_comb begin
    head_d  = head_r;
    tail_d  = tail_r;
    count_d = count_r;
    if (q.i_flush) begin
      head_d  = QPTR_RST;
      tail_d  = QPTR_RST;
      count_d = QPTR_RST;
    end else begin
      if (enq_fire) tail_d = tail_nxt;
      if (deq_fire) head_d = head_nxt;
      case ({enq_fire, deq_fire})
        2'b10:   count_d = count_inc;
        2'b01:   count_d = count_dec;
        default: count_d = count_r;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_r  <= QPTR_RST;
      tail_r  <= QPTR_RST;
      count_r <= QPTR_RST;
    end else begin
      head_r  <= head_d;
      tail_r  <= tail_d;
      count_r <= count_d;
    end
  end

  // Every output below depends on registered state only.
  assign q.o_enq_ready = ~full;
  assign q.o_deq_valid = ~empty;
  assign q.o_enq_ptr   = tail_r[QPTR_IDX_W-1:0];
  assign q.o_deq_ptr   = head_r[QPTR_IDX_W-1:0];
  assign q.o_count     = count_r;
  assign q.o_full      = full;
  assign q.o_empty     = empty;
  assign q.o_afull     = (32'(count_r) >= AFULL_THRESH);

endmodule

// File: tb/tb_common_qptr_ctrl32.sv
// Directed bench for common_qptr_ctrl32: reset, fill, wrap, concurrent traffic, full, flush.
module tb_common_qptr_ctrl32;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  common_qptr_ctrl32_if qif ();

  common_qptr_ctrl32 #(.AFULL_THRESH(28)) dut (
    .clk    (clk),
    .resetn (resetn),
    .q      (qif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Occupancy must always equal tail minus head modulo 64.
  always @(negedge clk) begin
    if (resetn) begin
      logic [5:0] diff;
      diff = dut.tail_r - dut.head_r;
      checks++;
      assert (dut.count_r === diff)
      else begin
        errors++;
        $error("FAIL invariant observed=%0h expected=%0h", dut.count_r, diff);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    qif.i_enq_valid = 1'b0;
    qif.i_deq_ready = 1'b0;
    qif.i_flush     = 1'b0;
    tick();
    tick();
    chk("rst_count", 32'(qif.o_count), 32'd0);
    chk("rst_empty", 32'(qif.o_empty), 32'd1);
    chk("rst_full", 32'(qif.o_full), 32'd0);
    chk("rst_afull", 32'(qif.o_afull), 32'd0);
    chk("rst_enq_ready", 32'(qif.o_enq_ready), 32'd1);
    chk("rst_deq_valid", 32'(qif.o_deq_valid), 32'd0);
    chk("rst_enq_ptr", 32'(qif.o_enq_ptr), 32'd0);
    chk("rst_deq_ptr", 32'(qif.o_deq_ptr), 32'd0);
    resetn = 1'b1;
    tick();

    // Fill from empty
    qif.i_enq_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      chk("fill_enq_ptr", 32'(qif.o_enq_ptr), 32'(i));
      chk("fill_afull", 32'(qif.o_afull), (i >= 28) ? 32'd1 : 32'd0);
      if (i == 0) chk("no_fallthru", 32'(qif.o_deq_valid), 32'd0);
      tick();
      if (i == 0) chk("enq_latency", 32'(qif.o_deq_valid), 32'd1);
    end
    chk("fill_full", 32'(qif.o_full), 32'd1);
    chk("fill_enq_ready", 32'(qif.o_enq_ready), 32'd0);
    chk("fill_count", 32'(qif.o_count), 32'd32);
    chk("fill_tail", 32'(dut.tail_r), 32'h20);
    chk("fill_afull_end", 32'(qif.o_afull), 32'd1);
    tick();
    chk("full_hold_count", 32'(qif.o_count), 32'd32);
    chk("full_hold_tail", 32'(dut.tail_r), 32'h20);

    // Drain across wrap
    qif.i_enq_valid = 1'b0;
    qif.i_deq_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      chk("drain_deq_ptr", 32'(qif.o_deq_ptr), 32'(i));
      tick();
    end
    chk("drain_empty", 32'(qif.o_empty), 32'd1);
    chk("drain_count", 32'(qif.o_count), 32'd0);
    chk("drain_head", 32'(dut.head_r), 32'h20);
    chk("drain_deq_valid", 32'(qif.o_deq_valid), 32'd0);
    tick();
    chk("empty_deq_count", 32'(qif.o_count), 32'd0);
    chk("empty_deq_head", 32'(dut.head_r), 32'h20);

    qif.i_deq_ready = 1'b0;
    qif.i_enq_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("wrap_enq_ptr", 32'(qif.o_enq_ptr), 32'(i));
      tick();
    end
    chk("wrap_count", 32'(qif.o_count), 32'd3);
    chk("wrap_tail", 32'(dut.tail_r), 32'h23);

    // Simultaneous enq+deq at count 10
    repeat (7) tick();
    chk("pre_sim_count", 32'(qif.o_count), 32'd10);
    chk("pre_sim_tail", 32'(dut.tail_r), 32'h2a);
    qif.i_deq_ready = 1'b1;
    repeat (40) tick();
    chk("sim_count", 32'(qif.o_count), 32'd10);
    chk("sim_head", 32'(dut.head_r), 32'h08);
    chk("sim_tail", 32'(dut.tail_r), 32'h12);

    // Full with dequeue in the same cycle
    qif.i_deq_ready = 1'b0;
    repeat (22) tick();
    chk("refill_full", 32'(qif.o_full), 32'd1);
    chk("refill_count", 32'(qif.o_count), 32'd32);
    chk("refill_tail", 32'(dut.tail_r), 32'h28);
    qif.i_deq_ready = 1'b1;
    chk("full_enq_ready", 32'(qif.o_enq_ready), 32'd0);
    tick();
    chk("full_deq_count", 32'(qif.o_count), 32'd31);
    chk("full_deq_full", 32'(qif.o_full), 32'd0);
    chk("full_deq_head", 32'(dut.head_r), 32'h09);
    chk("full_deq_tail", 32'(dut.tail_r), 32'h28);
    qif.i_deq_ready = 1'b0;
    tick();
    chk("reaccept_count", 32'(qif.o_count), 32'd32);
    chk("reaccept_tail", 32'(dut.tail_r), 32'h29);
    chk("reaccept_full", 32'(qif.o_full), 32'd1);

    // Flush at count 17 with both handshakes active
    qif.i_enq_valid = 1'b0;
    qif.i_deq_ready = 1'b1;
    repeat (15) tick();
    chk("pre_flush_count", 32'(qif.o_count), 32'd17);
    chk("pre_flush_head", 32'(dut.head_r), 32'h18);
    qif.i_enq_valid = 1'b1;
    qif.i_flush     = 1'b1;
    tick();
    qif.i_flush     = 1'b0;
    qif.i_enq_valid = 1'b0;
    qif.i_deq_ready = 1'b0;
    chk("flush_count", 32'(qif.o_count), 32'd0);
    chk("flush_empty", 32'(qif.o_empty), 32'd1);
    chk("flush_head", 32'(dut.head_r), 32'd0);
    chk("flush_tail", 32'(dut.tail_r), 32'd0);
    chk("flush_enq_ptr", 32'(qif.o_enq_ptr), 32'd0);
    chk("flush_deq_ptr", 32'(qif.o_deq_ptr), 32'd0);

    // Queue 5 entries, then reset asynchronously mid-cycle
    qif.i_enq_valid = 1'b1;
    repeat (5) tick();
    qif.i_enq_valid = 1'b0;
    chk("prerst_count", 32'(qif.o_count), 32'd5);
    chk("prerst_enq_ptr", 32'(qif.o_enq_ptr), 32'd5);
    #3;
    resetn = 1'b0;
    #1;
    chk("async_count", 32'(qif.o_count), 32'd0);
    chk("async_empty", 32'(qif.o_empty), 32'd1);
    chk("async_enq_ready", 32'(qif.o_enq_ready), 32'd1);
    chk("async_deq_valid", 32'(qif.o_deq_valid), 32'd0);
    chk("async_enq_ptr", 32'(qif.o_enq_ptr), 32'd0);
    chk("async_deq_ptr", 32'(qif.o_deq_ptr), 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    chk("post_rst_count", 32'(qif.o_count), 32'd0);
    chk("post_rst_empty", 32'(qif.o_empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/common_qptr_ctrl32.md
Name: common_qptr_ctrl32

Overview:
- Pointer controller for a 32-entry circular queue, e.g. a store buffer or fetch queue built on a separate 32x storage array.
- Owns the head/tail pointers with wrap bits, the valid/ready handshakes, occupancy count and flush.
- All pointer advances use the 5-bit increment ROM. The storage array indexes with o_enq_ptr / o_deq_ptr.

Parameters:
AFULL_THRESH, 28, occupancy at or above which o_afull asserts (legal range 1..32)

Ports:
clk  input  1  clock, all state updates on rising edge
resetn  input  1  asynchronous active-low reset
i_enq_valid  input  1  requester offers one entry this cycle
o_enq_ready  output  1  controller accepts an entry (= !full)
o_enq_ptr  output  5  slot index to write when the enqueue fires
i_deq_ready  input  1  consumer takes the head entry this cycle
o_deq_valid  output  1  head entry present (= !empty)
o_deq_ptr  output  5  slot index of the head entry
i_flush  input  1  synchronous discard of all entries
o_count  output  6  current occupancy, 0..32
o_full  output  1  occupancy == 32
o_empty  output  1  occupancy == 0
o_afull  output  1  o_count >= AFULL_THRESH

Behaviour:
- **State:** head_r[5:0] and tail_r[5:0] (bit 5 = wrap, bits 4:0 = index), plus count_r[5:0].
- **Reset:** resetn low asynchronously forces head_r=0, tail_r=0, count_r=0. Outputs during and after reset:
  - o_empty=1, o_full=0, o_afull=0, o_count=0
  - o_enq_ready=1, o_deq_valid=0
  - o_enq_ptr=0, o_deq_ptr=0
- **Pointer increment:** {c,q} = incr5(ptr[4:0]); next = {ptr[5]^c, q}. Index 31 wraps to 0 and toggles the wrap bit. No '+' operator on pointers.
- **Status decode:**
  - empty: head_r == tail_r (all 6 bits)
  - full: index bits equal, wrap bits differ
  - o_count, o_full, o_empty and o_afull are decoded from registers only; no combinational path from any input to any output.
- **Handshake fires:**
  - enq_fire = i_enq_valid & o_enq_ready
  - deq_fire = i_deq_ready & o_deq_valid
  - Requester may hold i_enq_valid while not ready; nothing changes until it fires.
- **Updates on clk rising edge (i_flush=0):**
  - enq_fire: tail_r <= next(tail_r)
  - deq_fire: head_r <= next(head_r)
  - count_r: +1 if only enq fires; -1 if only deq fires; unchanged if both or neither.
- **Latency:** entry enqueued in cycle n is visible as o_deq_valid in cycle n+1. No fall-through when empty, no bypass when full.
- **Full:** o_enq_ready=0. A dequeue in the same cycle frees a slot only for cycle n+1 (enq not accepted in cycle n).
- **Empty:** o_deq_valid=0; i_deq_ready ignored.
- **Simultaneous enq+deq (neither full nor empty):** both pointers advance, count unchanged.
- **Flush:** i_flush=1 sets head_r=tail_r=0 and count_r=0 at the next edge. Overrides any enq/deq fire in the same cycle; those transfers are discarded.
- **Reset mid-operation:** all entries are lost, state returns to reset values immediately, no partial update.
- **Invariant:** count_r == (tail_r - head_r) mod 64 at all times; the bench checks this as an assertion.

Decomposition:
- Shared package/include holds:
  - QPTR_IDX_W=5, QPTR_W=6, QPTR_DEPTH=32
  - reset pointer value 6'd0
- Sub-module: common_rtlrom_incr5, instantiated three times:
  - tail index advance
  - head index advance
  - count up-step (count_r[4:0] plus carry into bit 5)
- Count down-step is done with a local comparison-free decrement, written as a sibling ROM common_rtlrom_decr5 if the team wants symmetry; otherwise inline.

Test Plan:
- **Reset:** assert resetn=0 mid-cycle with 5 entries queued -> outputs immediately count=0, empty=1, enq_ready=1, enq_ptr=0, deq_ptr=0.
- **Fill:** 32 consecutive enq_fire from empty -> o_enq_ptr steps 0..31; after 32nd edge full=1, enq_ready=0, count=32, tail_r=6'b100000. afull first asserts after the 28th enqueue.
- **Drain across wrap:** from full, 32 dequeues -> deq_ptr steps 0..31 then empty=1, head_r=6'b100000. Then 3 more enqueues -> enq_ptr 0,1,2 with wrap bit set, count=3.
- **Simultaneous enq+deq:** at count=10, hold enq_valid=1 and deq_ready=1 for 40 cycles -> count stays 10, both pointers wrap past 31 to 0.
- **Full with deq_ready:** at full, enq_valid=1 and deq_ready=1 in the same cycle -> enq rejected, count=31 next cycle; enq accepted the following cycle, count back to 32.
- **Flush:** flush with enq_valid=1 and deq_ready=1 at count=17 -> next cycle count=0, empty=1, both pointers 0; next enq uses ptr 0.
